data_memory_arbiter: RTL and testbench

- Shares the single-port DataMemory (36-bit words, 2048 deep) between NUM_CORES processor cores using round-robin arbitration.
- Serialises core load/store requests onto the memory's writeEn/dataIn/address port and returns dataOut to the requesting core with a one-cycle ack.
- Drives the memory's processDone once every core reports completion and the arbiter is idle.
- Sits between the per-core memory stages and the DataMemory instance at top level.

---
 rtl/data_memory_arbiter.sv | 131 +++++++++++++
 tb/tb_data_memory_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_CORES cores.
// Each transaction takes grant -> access -> respond, with a one-cycle ack back to the core.
module data_memory_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int WIDTH      = 36,
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            core_req,
    input  logic [NUM_CORES-1:0]            core_we,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*WIDTH-1:0]      core_wdata,
    input  logic [NUM_CORES-1:0]            core_done,
    output logic [NUM_CORES-1:0]            core_ack,
    output logic [WIDTH-1:0]                core_rdata,
    output logic                            mem_writeEn,
    output logic [WIDTH-1:0]                mem_dataIn,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    input  logic [WIDTH-1:0]                mem_dataOut,
    output logic                            mem_processDone
);

    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic                    load_q, load_d;
    logic [NUM_CORES-1:0]    ack_q, ack_d;
    logic [WIDTH-1:0]        rdata_q, rdata_d;
    logic                    we_q, we_d;
    logic [WIDTH-1:0]        din_q, din_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    pd_q, pd_d;

    logic [NUM_CORES-1:0]    eligible;
    logic                    found;
    logic [GW-1:0]           pick;
    logic [GW-1:0]           cand;

    // The core currently being acked is masked so a held req counts as a fresh request later.
    always_comb begin
        eligible = core_req & ~ack_q;
        found    = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NUM_CORES);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        load_d       = load_q;
        ack_d        = '0;
        rdata_d      = rdata_q;
        we_d         = we_q;
        din_d        = din_q;
        addr_d       = addr_q;
        pd_d         = pd_q | ((&core_done) && (state_q == StIdle) && (core_req == '0));
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    load_d  = ~core_we[pick];
                    we_d    = core_we[pick];
                    addr_d  = core_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    din_d   = core_wdata[int'(pick)*WIDTH +: WIDTH];
                    state_d = StAccess;
                end
            end
            StAccess: begin
                we_d    = 1'b0;
                state_d = StRespond;
            end
            StRespond: begin
                ack_d[grant_q] = 1'b1;
                if (load_q) begin
                    rdata_d = mem_dataOut;
                end
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CORES - 1);
            load_q       <= 1'b0;
            ack_q        <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
            din_q        <= '0;
            addr_q       <= '0;
            pd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            load_q       <= load_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            din_q        <= din_d;
            addr_q       <= addr_d;
            pd_q         <= pd_d;
        end
    end

    assign core_ack        = ack_q;
    assign core_rdata      = rdata_q;
    assign mem_writeEn     = we_q;
    assign mem_dataIn      = din_q;
    assign mem_address     = addr_q;
    assign mem_processDone = pd_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: transaction-timeline reference model, directed scenarios
// with literal expectations, then randomized multi-core traffic.
module tb_data_memory_arbiter;
    localparam int NC = 4;
    localparam int W  = 36;
    localparam int D  = 2048;
    localparam int AW = 11;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     core_req = '0;
    logic [NC-1:0]     core_we = '0;
    logic [NC-1:0]     core_done = '0;
    logic [NC*AW-1:0]  core_addr = '0;
    logic [NC*W-1:0]   core_wdata = '0;
    logic [NC-1:0]     core_ack;
    logic [W-1:0]      core_rdata;
    logic              mem_writeEn;
    logic [W-1:0]      mem_dataIn;
    logic [AW-1:0]     mem_address;
    logic [W-1:0]      mem_dataOut;
    logic              mem_processDone;

    always #5 clock = ~clock;

    data_memory_arbiter #(.NUM_CORES(NC), .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .core_req        (core_req),
        .core_we         (core_we),
        .core_addr       (core_addr),
        .core_wdata      (core_wdata),
        .core_done       (core_done),
        .core_ack        (core_ack),
        .core_rdata      (core_rdata),
        .mem_writeEn     (mem_writeEn),
        .mem_dataIn      (mem_dataIn),
        .mem_address     (mem_address),
        .mem_dataOut     (mem_dataOut),
        .mem_processDone (mem_processDone)
    );

    // DataMemory stand-in: synchronous write, registered read; cleared once at first reset.
    logic [W-1:0] ram [D];
    bit           ram_clr = 1'b0;
    always @(posedge clock) begin
        if (!ram_clr) begin
            for (int i = 0; i < D; i++) ram[i] <= '0;
            ram_clr     <= 1'b1;
            mem_dataOut <= '0;
        end else begin
            if (mem_writeEn) ram[mem_address] <= mem_dataIn;
            mem_dataOut <= ram[mem_address];
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: transaction timeline (grant at edge n, store commits at n+1, ack at n+2).
    logic [NC-1:0] exp_ack;
    logic [W-1:0]  exp_rdata, exp_din;
    logic [AW-1:0] exp_addr;
    logic          exp_we, exp_pd;
    logic [W-1:0]  shadow [D];
    bit            busy;
    int            g, last, cyc, gcyc;
    bit            gwe;
    logic [AW-1:0] gaddr;
    logic [W-1:0]  gdata;

    initial begin
        logic [NC-1:0] prev_ack, elig;
        bit was_busy, found;
        int c;
        for (int i = 0; i < D; i++) shadow[i] = '0;
        exp_ack = '0; exp_rdata = '0; exp_din = '0; exp_addr = '0; exp_we = 0; exp_pd = 0;
        busy = 0; last = NC - 1; cyc = 0; gcyc = 0; g = 0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                exp_ack = '0; exp_rdata = '0; exp_din = '0; exp_addr = '0;
                exp_we = 0; exp_pd = 0; busy = 0; last = NC - 1;
            end else begin
                cyc++;
                prev_ack = exp_ack;
                was_busy = busy;
                exp_ack  = '0;
                if (busy && cyc == gcyc + 1) begin
                    exp_we = 1'b0;
                    if (gwe) shadow[gaddr] = gdata;
                end else if (busy && cyc == gcyc + 2) begin
                    exp_ack[g] = 1'b1;
                    if (!gwe) exp_rdata = shadow[gaddr];
                    last = g;
                    busy = 0;
                end else begin
                    elig  = core_req & ~prev_ack;
                    found = 0;
                    for (int k = 1; k <= NC; k++) begin
                        c = (last + k) % NC;
                        if (!found && elig[c]) begin
                            found = 1;
                            g     = c;
                        end
                    end
                    if (found) begin
                        busy     = 1;
                        gcyc     = cyc;
                        gwe      = core_we[g];
                        gaddr    = core_addr[g*AW +: AW];
                        gdata    = core_wdata[g*W +: W];
                        exp_we   = gwe;
                        exp_addr = gaddr;
                        exp_din  = gdata;
                    end
                end
                if (!was_busy && (&core_done) && core_req == '0) exp_pd = 1'b1;
            end
        end
    end

    bit cmp_en = 0;
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en && !reset) begin
                chk("m_ack", core_ack, exp_ack);
                chk("m_rdata", core_rdata, exp_rdata);
                chk("m_we", mem_writeEn, exp_we);
                chk("m_addr", mem_address, exp_addr);
                chk("m_din", mem_dataIn, exp_din);
                chk("m_pd", mem_processDone, exp_pd);
            end
        end
    end

    int            got_core[$];
    int            got_b[$];
    logic [W-1:0]  got_rd[$];
    logic [NC-1:0] got_vec[$];
    int            we_cnt;
    logic [AW-1:0] cap_addr;
    logic [W-1:0]  cap_din;

    task automatic do_reset();
        @(negedge clock);
        #1 reset = 1'b1;
        core_req = '0;
        @(negedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic set_core(input int c, input bit we, input logic [AW-1:0] a,
                            input logic [W-1:0] d);
        core_req[c] = 1'b1;
        core_we[c]  = we;
        core_addr[c*AW +: AW] = a;
        core_wdata[c*W +: W]  = d;
    endtask

    task automatic wait_acks(input int n, input logic [NC-1:0] hold, input int budget);
        got_core.delete(); got_b.delete(); got_rd.delete(); got_vec.delete();
        we_cnt = 0;
        for (int b = 1; b <= budget && got_core.size() < n; b++) begin
            @(negedge clock);
            if (mem_writeEn) begin
                we_cnt++;
                cap_addr = mem_address;
                cap_din  = mem_dataIn;
            end
            if (core_ack != '0) got_vec.push_back(core_ack);
            for (int c = 0; c < NC; c++) begin
                if (core_ack[c]) begin
                    got_core.push_back(c);
                    got_b.push_back(b);
                    got_rd.push_back(core_rdata);
                    if (!hold[c]) core_req[c] = 1'b0;
                end
            end
        end
        chk("ack_count", got_core.size(), n);
    endtask

    initial begin
        logic [63:0] r;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        cmp_en = 1;

        // Store then load of the same word.
        set_core(0, 1'b1, 11'h001, 36'h123);
        wait_acks(1, '0, 10);
        if (got_core.size() == 1) begin
            chk("t1_ackvec", got_vec[0], 4'b0001);
            chk("t1_latency", got_b[0], 3);
        end
        chk("t1_we_cycles", we_cnt, 1);
        chk("t1_addr", cap_addr, 11'h001);
        chk("t1_din", cap_din, 36'h123);
        set_core(2, 1'b0, 11'h001, '0);
        wait_acks(1, '0, 10);
        if (got_core.size() == 1) begin
            chk("t2_ackvec", got_vec[0], 4'b0100);
            chk("t2_rdata", got_rd[0], 36'h123);
        end
        chk("t2_we_cycles", we_cnt, 0);

        // Four simultaneous stores: strict order 0..3, one every 3 cycles.
        do_reset();
        for (int c = 0; c < NC; c++) set_core(c, 1'b1, 11'(16 + c), 36'(12'hA00 + c));
        wait_acks(4, '0, 20);
        if (got_core.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", got_core[i], i);
            for (int i = 1; i < 4; i++) chk("t3_spacing", got_b[i] - got_b[i-1], 3);
        end
        chk("t3_we_cycles", we_cnt, 4);
        @(negedge clock);
        for (int i = 0; i < 4; i++) chk("t3_ram", ram[16 + i], 36'(12'hA00 + i));

        // Core1 holds req, core3 asks once.
        do_reset();
        set_core(1, 1'b0, 11'h010, '0);
        set_core(3, 1'b0, 11'h013, '0);
        wait_acks(4, 4'b0010, 30);
        core_req[1] = 1'b0;
        if (got_core.size() == 4) begin
            chk("t4_g0", got_core[0], 1);
            chk("t4_g1", got_core[1], 3);
            chk("t4_g2", got_core[2], 1);
            chk("t4_g3", got_core[3], 1);
            chk("t4_rd3", got_rd[1], 36'hA03);
            chk("t4_gap_masked", got_b[3] - got_b[2], 4);
        end

        // Reset in the middle of a core0 load.
        do_reset();
        set_core(0, 1'b0, 11'h011, '0);
        @(negedge clock);
        chk("t5_access_addr", mem_address, 11'h011);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_ack", core_ack, '0);
        chk("t5_rst_rdata", core_rdata, '0);
        chk("t5_rst_we", mem_writeEn, 0);
        chk("t5_rst_din", mem_dataIn, '0);
        chk("t5_rst_addr", mem_address, '0);
        chk("t5_rst_pd", mem_processDone, 0);
        @(negedge clock);
        #1 reset = 1'b0;
        wait_acks(1, '0, 10);
        if (got_core.size() == 1) begin
            chk("t5_core", got_core[0], 0);
            chk("t5_latency", got_b[0], 3);
            chk("t5_rdata", got_rd[0], 36'hA01);
        end

        // Randomized traffic, checked every cycle by the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            for (int c = 0; c < NC; c++) begin
                r = {$urandom(), $urandom()};
                if (core_req[c]) begin
                    if (core_ack[c]) begin
                        if (r[40]) core_req[c] = 1'b0;
                        else begin
                            core_addr[c*AW +: AW] = r[41] ? 11'(r[3:0]) : 11'(2040 + r[2:0]);
                            core_wdata[c*W +: W]  = r[35:0];
                        end
                    end
                end else if (r[43:42] == 2'b00) begin
                    set_core(c, r[44], r[45] ? 11'(r[3:0]) : 11'(2040 + r[2:0]), r[35:0]);
                end
            end
        end
        core_req = '0;
        repeat (6) @(negedge clock);

        // processDone waits for the pending core2 transaction, then sticks.
        do_reset();
        set_core(2, 1'b1, 11'h7FF, 36'hFFFFFFFFF);
        core_done = 4'b1111;
        @(negedge clock);
        chk("t6_pd_pending", mem_processDone, 0);
        wait_acks(1, '0, 10);
        chk("t6_pd_ackcycle", mem_processDone, 0);
        @(negedge clock);
        chk("t6_pd_set", mem_processDone, 1);
        set_core(0, 1'b0, 11'h7FF, '0);
        wait_acks(1, '0, 10);
        if (got_core.size() == 1) chk("t6_rd_top", got_rd[0], 36'hFFFFFFFFF);
        repeat (3) @(negedge clock);
        chk("t6_pd_sticky", mem_processDone, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
